sequential_subtractor_16bit: RTL

Multi-cycle 16-bit subtractor. It is the inverse-direction counterpart to the team's carry-lookahead adder: it computes D = X − Y − Bin one 4-bit slice per clock, rippling the borrow between slices in a register. Operands arrive on a valid/ready input handshake and results leave on a valid/ready output handshake. It sits in the datapath wherever a small, area-cheap subtract/compare is needed and latency is not critical.

---
 rtl/sequential_subtractor_16bit_pkg.sv | 15 +
 rtl/subtract_slice_4bit.sv | 29 ++
 rtl/sequential_subtractor_16bit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sequential_subtractor_16bit_pkg.sv
// Purpose: shared FSM state encoding and default geometry for the sequential subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sequential_subtractor_16bit_pkg;

  localparam int WIDTH_DEF = 16;  // operand/result width
  localparam int SLICE_DEF = 4;   // bits resolved per CALC cycle

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtract_slice_4bit.sv
// Purpose: combinational SLICE-bit ripple-borrow subtractor, Dk = Xk - Yk - Bi.
// Latency: purely combinational.
// Backpressure: none; the parent FSM decides when the result is used.
module subtract_slice_4bit
  import sequential_subtractor_16bit_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] Xk,
  input  logic [SLICE-1:0] Yk,
  input  logic             Bi,
  output logic [SLICE-1:0] Dk,
  output logic             Bo
);

  logic b_chain;

  // Ripple the borrow from bit 0 upward; a bit borrows when x<y, or x==y with a pending borrow.
  always_comb begin
    Dk      = '0;
    b_chain = Bi;
    for (int i = 0; i < SLICE; i++) begin
      Dk[i]   = Xk[i] ^ Yk[i] ^ b_chain;
      b_chain = (~Xk[i] & Yk[i]) | (~(Xk[i] ^ Yk[i]) & b_chain);
    end
    Bo = b_chain;
  end

endmodule

// File: rtl/sequential_subtractor_16bit.sv
// Purpose: multi-cycle X - Y - Bin, one SLICE-bit chunk per clock with a registered borrow.
// Latency: accept at edge t, OutValid high after edge t+STEPS; one op in flight at a time.
// Backpressure: result held in DONE until OutReady; InReady low in CALC and DONE.
module sequential_subtractor_16bit
  import sequential_subtractor_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t            state_q,  state_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  x_q,      x_d;
  logic [WIDTH-1:0]  y_q,      y_d;
  logic [WIDTH-1:0]  d_q,      d_d;
  logic              bout_q,   bout_d;
  logic              v_q,      v_d;
  logic              z_q,      z_d;

  // Latched operands viewed as slices so the single slice unit can be muxed by the counter.
  logic [SLICE-1:0]  x_sl [STEPS];
  logic [SLICE-1:0]  y_sl [STEPS];
  logic [SLICE-1:0]  xk, yk, dk;
  logic              bo;

  for (genvar k = 0; k < STEPS; k++) begin : g_slices
    assign x_sl[k] = x_q[k*SLICE +: SLICE];
    assign y_sl[k] = y_q[k*SLICE +: SLICE];
  end

  assign xk = x_sl[cnt_q];
  assign yk = y_sl[cnt_q];

  subtract_slice_4bit #(
    .SLICE (SLICE)
  ) u_slice (
    .Xk (xk),
    .Yk (yk),
    .Bi (borrow_q),
    .Dk (dk),
    .Bo (bo)
  );

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign D        = d_q;
  assign Bout     = bout_q;
  assign V        = v_q;
  assign Z        = z_q;

  // State, counter, operand and result registers; reset discards any operation in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      x_q      <= x_d;
      y_q      <= y_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  // Next-state: accept in IDLE, one slice per CALC edge, flags resolved on the final slice.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    x_d      = x_q;
    y_d      = y_q;
    d_d      = d_q;
    bout_d   = bout_q;
    v_d      = v_q;
    z_d      = z_q;

    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          x_d      = X;
          y_d      = Y;
          borrow_d = Bin;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        for (int k = 0; k < STEPS; k++) begin
          if (cnt_q == CW'(k)) begin
            d_d[k*SLICE +: SLICE] = dk;
          end
        end
        borrow_d = bo;
        if (cnt_q == LAST) begin
          // d_d already holds the top slice here, so flags see the complete difference.
          cnt_d   = '0;
          state_d = DONE;
          bout_d  = bo;
          z_d     = (d_d == '0);
          v_d     = (x_q[WIDTH-1] != y_q[WIDTH-1]) & (d_d[WIDTH-1] != x_q[WIDTH-1]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (OutReady) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
